// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared jump-cause / hold-level encodings decoded by the PC stage
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        JC_NO              = 3'd0,
        JC_NOCOND          = 3'd1,
        JC_PRED_NO_BUT_YES = 3'd2,
        JC_PRED_YES_BUT_NO = 3'd3,
        JC_INTERRUPT       = 3'd4,
        JC_EXCEPTION       = 3'd5
    } jump_cause_e;

    // Each level freezes its own stage and everything upstream of it.
    typedef enum logic [2:0] {
        HOLD_NO = 3'd0,
        HOLD_PC = 3'd1,
        HOLD_IF = 3'd2,
        HOLD_ID = 3'd3,
        HOLD_EX = 3'd4
    } hold_e;

    localparam int CNT_W = 3;

    function automatic logic is_mispred(input logic [2:0] cause);
        return (cause == JC_PRED_NO_BUT_YES) || (cause == JC_PRED_YES_BUT_NO);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - redirect/hold command bus from pipe_ctrl to the PC stage
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [2:0]        jump_cause;
    logic [ADDR_W-1:0] jump_from_addr;
    logic [ADDR_W-1:0] jump_to_addr;
    logic [2:0]        hold_flag;
    logic              flush;

    modport master (output jump_cause, jump_from_addr, jump_to_addr, hold_flag, flush);
    modport slave  (input  jump_cause, jump_from_addr, jump_to_addr, hold_flag, flush);
endinterface

// File: rtl/pipe_ctrl_stat.sv
// rtl/pipe_ctrl_stat.sv - saturating mispredict / redirect counter pair
module pipe_ctrl_stat (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        mispred_i,
    input  logic        redirect_i,
    output logic [31:0] mispred_cnt_o,
    output logic [31:0] redirect_cnt_o
);
    logic [31:0] mispred_q, redirect_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_q  <= '0;
            redirect_q <= '0;
        end else if (clr_i) begin
            mispred_q  <= '0;
            redirect_q <= '0;
        end else begin
            if (mispred_i && (mispred_q != '1))
                mispred_q <= mispred_q + 32'd1;
            if (redirect_i && (redirect_q != '1))
                redirect_q <= redirect_q + 32'd1;
        end
    end

    assign mispred_cnt_o  = mispred_q;
    assign redirect_cnt_o = redirect_q;
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - redirect/stall arbiter and flush sequencer; PIPE_CTRL_STATS_EN adds counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ex_jump_cause_i,
    input  logic [ADDR_W-1:0] ex_jump_from_addr_i,
    input  logic [ADDR_W-1:0] ex_jump_to_addr_i,
    input  logic              exc_req_i,
    input  logic [ADDR_W-1:0] exc_vector_i,
    input  logic              irq_req_i,
    input  logic [ADDR_W-1:0] irq_vector_i,
    output logic              irq_ack_o,
    input  logic              load_use_i,
    input  logic              bus_wait_i,
    input  logic              halt_req_i,
    input  logic              resume_req_i,
    output logic              halted_o,
    pipe_ctrl_if.master       cmd
`ifdef PIPE_CTRL_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       mispred_cnt_o,
    output logic [31:0]       redirect_cnt_o
`endif
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_e;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt_pend_q, halt_pend_d;

    logic [2:0]        cause_c, hold_c;
    logic [ADDR_W-1:0] from_c, to_c;
    logic              ack_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        cause_c     = JC_NO;
        hold_c      = HOLD_NO;
        from_c      = '0;
        to_c        = '0;
        ack_c       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (exc_req_i) begin
                    cause_c = JC_EXCEPTION;
                    to_c    = exc_vector_i;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (ex_jump_cause_i != JC_NO) begin
                    cause_c = ex_jump_cause_i;
                    from_c  = ex_jump_from_addr_i;
                    to_c    = ex_jump_to_addr_i;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (irq_req_i && !bus_wait_i && !load_use_i) begin
                    cause_c = JC_INTERRUPT;
                    to_c    = irq_vector_i;
                    ack_c   = 1'b1;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (halt_req_i && !bus_wait_i) begin
                    state_d = ST_HALT;
                    hold_c  = load_use_i ? HOLD_ID : HOLD_NO;
                end else if (bus_wait_i) begin
                    hold_c = HOLD_EX;
                end else if (load_use_i) begin
                    hold_c = HOLD_ID;
                end
            end
            ST_FLUSH: begin
                // Squashed EX results are ignored here; only exceptions may re-redirect.
                if (halt_req_i)
                    halt_pend_d = 1'b1;
                if (exc_req_i) begin
                    cause_c = JC_EXCEPTION;
                    to_c    = exc_vector_i;
                    cnt_d   = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d     = (halt_pend_q || halt_req_i) ? ST_HALT : ST_RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                hold_c = HOLD_EX;
                if (resume_req_i)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, even with live inputs.
    assign cmd.jump_cause     = rst ? JC_NO : cause_c;
    assign cmd.jump_from_addr = rst ? '0 : from_c;
    assign cmd.jump_to_addr   = rst ? '0 : to_c;
    assign cmd.hold_flag      = rst ? HOLD_NO : hold_c;
    assign cmd.flush          = !rst && (state_q == ST_FLUSH);
    assign halted_o           = !rst && (state_q == ST_HALT);
    assign irq_ack_o          = !rst && ack_c;

`ifdef PIPE_CTRL_STATS_EN
    pipe_ctrl_stat u_stat (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (stat_clr_i),
        .mispred_i     (!rst && is_mispred(cause_c)),
        .redirect_i    (!rst && (cause_c != JC_NO)),
        .mispred_cnt_o (mispred_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
    );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ex_cause;
    logic [31:0] ex_from, ex_to, exc_vec, irq_vec;
    logic        exc_req, irq_req, irq_ack, load_use, bus_wait, halt_req, resume_req, halted;
    int          checks = 0;
    int          errors = 0;
`ifdef PIPE_CTRL_STATS_EN
    logic        stat_clr;
    logic [31:0] mispred_cnt, redirect_cnt;
`endif

    pipe_ctrl_if #(.ADDR_W(32)) cmd_if ();

    pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_jump_cause_i    (ex_cause),
        .ex_jump_from_addr_i(ex_from),
        .ex_jump_to_addr_i  (ex_to),
        .exc_req_i          (exc_req),
        .exc_vector_i       (exc_vec),
        .irq_req_i          (irq_req),
        .irq_vector_i       (irq_vec),
        .irq_ack_o          (irq_ack),
        .load_use_i         (load_use),
        .bus_wait_i         (bus_wait),
        .halt_req_i         (halt_req),
        .resume_req_i       (resume_req),
        .halted_o           (halted),
        .cmd                (cmd_if)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stat_clr_i         (stat_clr),
        .mispred_cnt_o      (mispred_cnt),
        .redirect_cnt_o     (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ex_cause = 3'd0; ex_from = '0; ex_to = '0;
        exc_req = 1'b0; exc_vec = 32'h1000; irq_req = 1'b0; irq_vec = 32'h2000;
        load_use = 1'b0; bus_wait = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
`ifdef PIPE_CTRL_STATS_EN
        stat_clr = 1'b0;
`endif
        tick();
        chk("rst_cause", cmd_if.jump_cause, 32'd0);
        chk("rst_hold", cmd_if.hold_flag, 32'd0);
        chk("rst_flush", cmd_if.flush, 32'd0);
        chk("rst_halted", halted, 32'd0);
        chk("rst_to", cmd_if.jump_to_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_cause", cmd_if.jump_cause, 32'd0);

        // Mispredict redirect, then flush bubbles that swallow a squashed EX cause
        ex_cause = 3'd2; ex_from = 32'h40; ex_to = 32'h80; #1;
        chk("br_cause", cmd_if.jump_cause, 32'd2);
        chk("br_to", cmd_if.jump_to_addr, 32'h80);
        chk("br_from", cmd_if.jump_from_addr, 32'h40);
        chk("br_flush_now", cmd_if.flush, 32'd0);
        tick();
        ex_cause = 3'd3; ex_to = 32'h100; #1;
        chk("fl1_flush", cmd_if.flush, 32'd1);
        chk("fl1_cause", cmd_if.jump_cause, 32'd0);
        tick();
        chk("fl2_flush", cmd_if.flush, 32'd1);
        chk("fl2_cause", cmd_if.jump_cause, 32'd0);
        tick();
        ex_cause = 3'd0; #1;
        chk("fl_end", cmd_if.flush, 32'd0);

        // Exception beats EX jump and interrupt; interrupt issues after the flush
        exc_req = 1'b1; irq_req = 1'b1; ex_cause = 3'd1; ex_to = 32'h300; #1;
        chk("exc_cause", cmd_if.jump_cause, 32'd5);
        chk("exc_to", cmd_if.jump_to_addr, 32'h1000);
        chk("exc_from", cmd_if.jump_from_addr, 32'h0);
        chk("exc_ack", irq_ack, 32'd0);
        tick();
        exc_req = 1'b0; ex_cause = 3'd0; #1;
        chk("exc_fl1_ack", irq_ack, 32'd0);
        chk("exc_fl1_flush", cmd_if.flush, 32'd1);
        tick();
        chk("exc_fl2_ack", irq_ack, 32'd0);
        tick();
        chk("irq_cause", cmd_if.jump_cause, 32'd4);
        chk("irq_to", cmd_if.jump_to_addr, 32'h2000);
        chk("irq_ack", irq_ack, 32'd1);
        tick();
        irq_req = 1'b0; #1;
        chk("irq_ack_drop", irq_ack, 32'd0);
        tick(); tick();
        chk("irq_fl_end", cmd_if.flush, 32'd0);

        // Interrupt held off by bus wait for three cycles
        irq_req = 1'b1; bus_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bw_hold", cmd_if.hold_flag, 32'd4);
            chk("bw_ack", irq_ack, 32'd0);
            tick();
        end
        bus_wait = 1'b0; #1;
        chk("bw_irq_cause", cmd_if.jump_cause, 32'd4);
        chk("bw_irq_ack", irq_ack, 32'd1);
        chk("bw_irq_hold", cmd_if.hold_flag, 32'd0);
        tick();
        irq_req = 1'b0;
        tick(); tick();

        // Stall priority
        load_use = 1'b1; bus_wait = 1'b1; #1;
        chk("lu_bw_hold", cmd_if.hold_flag, 32'd4);
        bus_wait = 1'b0; #1;
        chk("lu_hold", cmd_if.hold_flag, 32'd3);
        load_use = 1'b0; #1;
        chk("no_hold", cmd_if.hold_flag, 32'd0);
        tick();

        // Exception inside FLUSH reloads the bubble counter
        ex_cause = 3'd3; ex_to = 32'h600; #1;
        chk("m2_cause", cmd_if.jump_cause, 32'd3);
        tick();
        ex_cause = 3'd0; exc_req = 1'b1; #1;
        chk("fexc_cause", cmd_if.jump_cause, 32'd5);
        chk("fexc_flush", cmd_if.flush, 32'd1);
        tick();
        exc_req = 1'b0; #1;
        chk("fexc_fl1", cmd_if.flush, 32'd1);
        tick();
        chk("fexc_fl2", cmd_if.flush, 32'd1);
        tick();
        chk("fexc_end", cmd_if.flush, 32'd0);

        // Halt requested during FLUSH takes effect when the bubbles finish
        ex_cause = 3'd1; ex_to = 32'h500; #1;
        chk("h_jump", cmd_if.jump_cause, 32'd1);
        tick();
        ex_cause = 3'd0; halt_req = 1'b1; #1;
        chk("h_fl1_halted", halted, 32'd0);
        tick();
        halt_req = 1'b0; #1;
        chk("h_fl2_flush", cmd_if.flush, 32'd1);
        tick();
        exc_req = 1'b1; #1;
        chk("halted", halted, 32'd1);
        chk("halt_hold", cmd_if.hold_flag, 32'd4);
        chk("halt_flush", cmd_if.flush, 32'd0);
        chk("halt_exc_ign", cmd_if.jump_cause, 32'd0);
        tick();
        exc_req = 1'b0; resume_req = 1'b1; #1;
        chk("halt_resume_cyc", halted, 32'd1);
        tick();
        resume_req = 1'b0; #1;
        chk("resumed", halted, 32'd0);
        chk("resumed_hold", cmd_if.hold_flag, 32'd0);

        // Simultaneous halt+resume: halt wins in RUN, resume wins in HALT
        halt_req = 1'b1; resume_req = 1'b1;
        tick();
        chk("hr_run_halt", halted, 32'd1);
        tick();
        halt_req = 1'b0; resume_req = 1'b0; #1;
        chk("hr_halt_resume", halted, 32'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; #1;
        chk("pre_rst_halted", halted, 32'd1);

        // Asynchronous reset mid-HALT
        #2 rst = 1'b1;
        #1;
        chk("arst_halted", halted, 32'd0);
        chk("arst_hold", cmd_if.hold_flag, 32'd0);
        chk("arst_flush", cmd_if.flush, 32'd0);
`ifdef PIPE_CTRL_STATS_EN
        chk("arst_mispred", mispred_cnt, 32'd0);
        chk("arst_redirect", redirect_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_halted", halted, 32'd0);
        chk("post_rst_hold", cmd_if.hold_flag, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
